// File: rtl/bus_sel_ctrl.sv
// -----------------------------------------------------------------------------
// bus_sel_ctrl
//
// Bus-source select controller that sits directly in front of the N_SRC:1 bus
// multiplexer. A start strobe in IDLE captures the request vector. The lowest
// set bit becomes the registered mux select, which is held for hold_len+1
// cycles. A one-cycle done pulse follows. A request with more than one bit set
// is flagged as a conflict for the whole transfer and counted in a saturating
// counter, so the control unit can detect illegal microcode.
//
// Ports
//   clk           in   system clock; all state changes on the rising edge
//   clr           in   synchronous active-low reset
//   start         in   request strobe; only looked at in IDLE
//   req           in   [N_SRC-1:0] register-out requests; bit i is source i
//   hold_len      in   [HOLD_W-1:0] extra drive cycles beyond the first
//   sel           out  [SEL_W-1:0] registered select to the bus mux
//   bus_valid     out  sel is valid and the bus is being driven
//   busy          out  controller is not in IDLE
//   done          out  one-cycle pulse after the final drive cycle
//   conflict      out  the captured request had more than one bit set
//   conflict_cnt  out  [CNT_W-1:0] saturating count of conflicted transfers
// -----------------------------------------------------------------------------
module bus_sel_ctrl #(
  parameter int N_SRC  = 32,
  parameter int SEL_W  = 5,
  parameter int HOLD_W = 4,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              start,
  input  logic [N_SRC-1:0]  req,
  input  logic [HOLD_W-1:0] hold_len,
  output logic [SEL_W-1:0]  sel,
  output logic              bus_valid,
  output logic              busy,
  output logic              done,
  output logic              conflict,
  output logic [CNT_W-1:0]  conflict_cnt
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] DRIVE = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  logic [1:0]        state;
  logic [HOLD_W-1:0] hold_cnt;

  // Priority encoder: the lowest set bit wins. The loop runs from the top bit
  // down, so the last match is the lowest index.
  function automatic logic [SEL_W-1:0] lowest_idx(input logic [N_SRC-1:0] r);
    logic [SEL_W-1:0] idx;
    idx = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (r[i]) idx = SEL_W'(i);
    end
    return idx;
  endfunction

  // More than one bit set: clearing the lowest set bit leaves something behind.
  function automatic logic multi_bit(input logic [N_SRC-1:0] r);
    return |(r & (r - N_SRC'(1)));
  endfunction

  // Saturating increment. The counter sticks at all-ones and never wraps.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == {CNT_W{1'b1}}) ? c : c + CNT_W'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (!clr) begin
      state        <= IDLE;
      hold_cnt     <= '0;
      sel          <= '0;
      bus_valid    <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      conflict     <= 1'b0;
      conflict_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          // An empty request is not a transfer, so nothing moves.
          if (start && (|req)) begin
            sel       <= lowest_idx(req);
            conflict  <= multi_bit(req);
            if (multi_bit(req)) conflict_cnt <= sat_inc(conflict_cnt);
            hold_cnt  <= hold_len;
            bus_valid <= 1'b1;
            busy      <= 1'b1;
            state     <= DRIVE;
          end
        end

        DRIVE: begin
          // Live req, hold_len and start are ignored until the transfer ends.
          if (hold_cnt == '0) begin
            bus_valid <= 1'b0;
            sel       <= '0;
            done      <= 1'b1;
            state     <= DONE;
          end else begin
            hold_cnt <= hold_cnt - HOLD_W'(1);
          end
        end

        DONE: begin
          // conflict stays set through DONE and is cleared on the way to IDLE.
          done     <= 1'b0;
          busy     <= 1'b0;
          conflict <= 1'b0;
          state    <= IDLE;
        end

        default: begin
          sel       <= '0;
          bus_valid <= 1'b0;
          busy      <= 1'b0;
          done      <= 1'b0;
          conflict  <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_sel_ctrl.sv
// -----------------------------------------------------------------------------
// tb_bus_sel_ctrl
//
// Self-checking bench for bus_sel_ctrl. The reference model describes each
// accepted transfer as a timeline anchored on the edge that accepted it:
// - the bus is driven for hold+1 cycles;
// - done is high in the following cycle;
// - the controller is idle after that.
// Directed sequences, a vector table and randomized traffic are all compared
// against this model.
// -----------------------------------------------------------------------------
module tb_bus_sel_ctrl;

  logic        clk = 1'b0;
  logic        clr;
  logic        start;
  logic [31:0] req;
  logic [3:0]  hold_len;
  logic [4:0]  sel;
  logic        bus_valid;
  logic        busy;
  logic        done;
  logic        conflict;
  logic [7:0]  conflict_cnt;

  bus_sel_ctrl #(.N_SRC(32), .SEL_W(5), .HOLD_W(4), .CNT_W(8)) dut (
    .clk          (clk),
    .clr          (clr),
    .start        (start),
    .req          (req),
    .hold_len     (hold_len),
    .sel          (sel),
    .bus_valid    (bus_valid),
    .busy         (busy),
    .done         (done),
    .conflict     (conflict),
    .conflict_cnt (conflict_cnt)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  // Transfer-timeline model
  int cyc      = 0;
  bit m_active = 0;
  int m_k      = 0;
  int m_h      = 0;
  int m_sel    = 0;
  bit m_conf   = 0;
  int m_cnt    = 0;

  typedef struct {
    logic [31:0] req;
    logic [3:0]  hold;
    logic [4:0]  sel;
    logic        conf;
  } vec_t;
  vec_t tbl[6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d actual=%h required=%h", nm, cyc, act, exp);
    end
  endtask

  function automatic int low_bit(input logic [31:0] r);
    int idx = 0;
    logic [31:0] t = r;
    while (!t[0] && idx < 32) begin
      t = t >> 1;
      idx++;
    end
    return idx;
  endfunction

  // One clock: update the model from the inputs sampled at this edge, then
  // compare every output 1 time unit after the edge.
  task automatic step(input string nm);
    int d;
    logic [31:0] expv;
    logic [31:0] actv;
    @(posedge clk);
    cyc++;
    if (!clr) begin
      m_active = 0;
      m_cnt    = 0;
    end else if (start && req != 0 && (!m_active || cyc >= m_k + m_h + 3)) begin
      m_active = 1;
      m_k      = cyc;
      m_h      = int'(hold_len);
      m_sel    = low_bit(req);
      m_conf   = ($countones(req) > 1);
      if (m_conf && m_cnt < 255) m_cnt++;
    end
    #1;
    expv = '0;
    expv[7:0] = 8'(m_cnt);
    if (m_active) begin
      d = cyc - m_k;
      if (d <= m_h) begin
        expv[16:12] = 5'(m_sel);
        expv[11] = 1'b1;
        expv[10] = 1'b1;
        expv[8]  = m_conf;
      end else if (d == m_h + 1) begin
        expv[10] = 1'b1;
        expv[9]  = 1'b1;
        expv[8]  = m_conf;
      end
    end
    actv = {15'd0, sel, bus_valid, busy, done, conflict, conflict_cnt};
    chk(nm, actv, expv);
  endtask

  // Start pulse followed by enough idle-input cycles to finish the transfer.
  task automatic xfer(input logic [31:0] r, input logic [3:0] h, input string nm);
    req = r; hold_len = h; start = 1'b1;
    step(nm);
    start = 1'b0;
    for (int i = 0; i < int'(h) + 2; i++) step(nm);
  endtask

  initial begin
    tbl[0] = '{32'h0001_0000, 4'd0,  5'd16, 1'b0};
    tbl[1] = '{32'h8000_0000, 4'd3,  5'd31, 1'b0};
    tbl[2] = '{32'h1234_5678, 4'd0,  5'd3,  1'b1};
    tbl[3] = '{32'h0000_0001, 4'd15, 5'd0,  1'b0};
    tbl[4] = '{32'h0000_0100, 4'd8,  5'd8,  1'b0};
    tbl[5] = '{32'hC000_0000, 4'd2,  5'd30, 1'b1};

    // Reset held with a pending start
    clr = 1'b0; start = 1'b1; req = 32'h0000_0010; hold_len = 4'd0;
    step("reset0");
    step("reset1");
    chk("reset_busy", {31'd0, busy}, 32'd0);
    start = 1'b0; clr = 1'b1;
    step("post_reset");
    step("post_reset");

    // Single source, no hold: latency and the done pulse
    req = 32'h0001_0000; hold_len = 4'd0; start = 1'b1;
    step("single");
    chk("single_sel", {27'd0, sel}, 32'd16);
    chk("single_bv", {31'd0, bus_valid}, 32'd1);
    start = 1'b0;
    step("single");
    chk("single_done", {31'd0, done}, 32'd1);
    step("single");
    chk("single_busy_off", {31'd0, busy}, 32'd0);

    // Hold of 3, retrigger attempt during DRIVE
    req = 32'h8000_0000; hold_len = 4'd3; start = 1'b1;
    step("hold");
    req = 32'h0000_0001; hold_len = 4'd0;
    step("hold_retrig");
    chk("hold_sel_kept", {27'd0, sel}, 32'd31);
    start = 1'b0;
    for (int i = 0; i < 4; i++) step("hold");

    // Conflict, then saturation of the counter
    xfer(32'h1234_5678, 4'd0, "conf");
    chk("conf_cnt1", {24'd0, conflict_cnt}, 32'd1);
    for (int i = 1; i < 256; i++) xfer(32'h1234_5678, 4'd0, "conf_rep");
    chk("conf_sat", {24'd0, conflict_cnt}, 32'd255);

    // Empty request
    start = 1'b1; req = 32'h0;
    for (int i = 0; i < 5; i++) step("empty");
    chk("empty_cnt", {24'd0, conflict_cnt}, 32'd255);
    start = 1'b0;

    // Reset in the third drive cycle
    req = 32'h0000_0100; hold_len = 4'd8; start = 1'b1;
    step("midrst");
    start = 1'b0;
    step("midrst");
    step("midrst");
    clr = 1'b0;
    step("midrst_clr");
    chk("midrst_cnt", {24'd0, conflict_cnt}, 32'd0);
    clr = 1'b1;
    step("midrst_idle");
    chk("midrst_nodone", {31'd0, done}, 32'd0);
    req = 32'h0000_0100; hold_len = 4'd1; start = 1'b1;
    step("midrst_new");
    chk("midrst_new_sel", {27'd0, sel}, 32'd8);
    start = 1'b0;
    step("midrst_new");
    step("midrst_new");
    step("midrst_new");

    // Vector table
    for (int v = 0; v < 6; v++) begin
      int bv_cnt;
      int done_cnt;
      req = tbl[v].req; hold_len = tbl[v].hold; start = 1'b1;
      step("tbl");
      chk("tbl_sel", {27'd0, sel}, {27'd0, tbl[v].sel});
      chk("tbl_conf", {31'd0, conflict}, {31'd0, tbl[v].conf});
      start = 1'b0;
      bv_cnt = int'(bus_valid);
      done_cnt = 0;
      for (int i = 0; i < int'(tbl[v].hold) + 3; i++) begin
        step("tbl");
        bv_cnt += int'(bus_valid);
        done_cnt += int'(done);
      end
      chk("tbl_bv_len", 32'(bv_cnt), 32'(int'(tbl[v].hold) + 1));
      chk("tbl_done_cnt", 32'(done_cnt), 32'd1);
    end

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      int kind;
      clr   = ($urandom_range(0, 59) != 0);
      start = ($urandom_range(0, 2) == 0);
      kind  = $urandom_range(0, 3);
      case (kind)
        0:       req = 32'h0;
        1:       req = 32'h1 << $urandom_range(0, 31);
        2:       req = (32'h1 << $urandom_range(0, 31)) | (32'h1 << $urandom_range(0, 31));
        default: req = $urandom;
      endcase
      hold_len = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15))
                                             : 4'($urandom_range(0, 2));
      step("rand");
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/bus_sel_ctrl.md
Name: bus_sel_ctrl

Overview:
- Bus-source select controller that sits directly upstream of the 32:1 bus multiplexer and drives its 5-bit select.
- Accepts a 32-bit one-hot-intended vector of register-out requests and latches it on a start strobe.
- Priority-encodes the latched vector to a source index and holds that select stable for a programmable number of cycles.
- Flags and counts multi-source conflicts so the control unit can detect illegal microcode.

Parameters:
N_SRC, 32, number of bus sources; must equal 2**SEL_W.
SEL_W, 5, select width presented to the bus mux.
HOLD_W, 4, width of the hold-length input.
CNT_W, 8, width of the saturating conflict counter.

Ports:
clk  input  1  system clock, all state updates on rising edge.
clr  input  1  synchronous active-low reset; sampled on rising clk edge.
start  input  1  request strobe; sampled only in IDLE.
req  input  N_SRC  register-out requests, bit i = source i wants the bus.
hold_len  input  HOLD_W  extra drive cycles beyond one (drive length = hold_len+1).
sel  output  SEL_W  registered select to the bus mux.
bus_valid  output  1  sel is valid and the bus is being driven.
busy  output  1  controller not in IDLE.
done  output  1  one-cycle pulse after the final drive cycle.
conflict  output  1  latched request had more than one bit set; held for the whole transfer.
conflict_cnt  output  CNT_W  saturating count of conflicted transfers since reset.

Behaviour:
- Reset (clr=0 at a rising edge): state=IDLE; all outputs and internal latches go to 0: sel=0, bus_valid=0, busy=0, done=0, conflict=0, conflict_cnt=0. Reset overrides everything, including mid-transfer; no done pulse is produced for an aborted transfer.
- States: IDLE, DRIVE, DONE.
- IDLE:
  - With start=1 and req!=0 at edge k:
    - latch req and hold_len;
    - sel = index of the lowest set bit of req;
    - conflict = 1 if popcount(req) > 1;
    - conflict_cnt increments by 1 if conflict (saturates at 2**CNT_W-1, no wrap);
    - load down-counter with hold_len; go to DRIVE.
  - sel, bus_valid and busy are visible from cycle k+1, giving one cycle of latency.
  - With start=1 and req==0: no transfer; stay in IDLE; no output changes.
  - With start=0: hold.
- DRIVE:
  - bus_valid=1 and busy=1.
  - sel and conflict stay constant; live req, hold_len and start are ignored.
  - If counter==0, go to DONE; otherwise decrement.
  - Total bus_valid cycles = hold_len+1 (1..16 for defaults).
- DONE:
  - Lasts exactly one cycle: done=1, busy=1, bus_valid=0, sel=0, conflict stays set. Then go to IDLE.
  - start during DONE is ignored, so the minimum start-to-start spacing is hold_len+3 cycles.
- IDLE outputs: sel=0, bus_valid=0, busy=0, done=0, conflict=0 (cleared on entry to IDLE); conflict_cnt retained.
- Widths: encoder output is SEL_W bits. Bit N_SRC-1 maps to sel = all ones; bit 0 maps to sel=0. sel=0 with bus_valid=1 legitimately selects source 0.
- Simultaneous start and clr=0: reset wins.

Test Plan:
1. Reset: clr=0 for 2 cycles with start=1, req=32'h0000_0010 -> all outputs 0, state IDLE; release clr -> still idle until the next start.
2. Single source: req=32'h0001_0000, hold_len=0, start pulse at edge k -> sel=5'b10000, bus_valid=1 in cycle k+1 only; done=1 in cycle k+2; busy deasserts in cycle k+3.
3. Hold: req=32'h8000_0000, hold_len=4'd3 -> sel=5'b11111, bus_valid high for exactly 4 cycles, then a 1-cycle done. Change req to 32'h1 and pulse start during DRIVE -> sel unchanged and no retrigger.
4. Conflict: req=32'h1234_5678, hold_len=0 -> sel=5'd3, conflict=1 through DRIVE and DONE, conflict_cnt=1. Repeat 256 times total -> conflict_cnt stays at 8'hFF.
5. Empty request: start=1, req=0 -> busy, bus_valid and done all stay 0 for 5 cycles and conflict_cnt is unchanged.
6. Mid-transfer reset: req=32'h0000_0100, hold_len=4'd8, assert clr=0 in the third drive cycle -> next cycle all outputs 0, conflict_cnt=0, no done pulse. A new start then works normally with sel=5'd8.
